// File: rtl/bus_sequencer.sv
// -----------------------------------------------------------------------------
// bus_sequencer
//
// Purpose:
//   Front-panel to PlayBus sequencer. A GO request that arrives asynchronously
//   is synchronised and edge-qualified, then starts a timed
//   SETUP -> STROBE (WAIT+1 clocks) -> HOLD sequence. This sequence drives the
//   PlayBus enables and strobes for the selected function code:
//     3 ROM->LED, 4 RAM->LED, 5 SW->RAM, 6 ROM->RAM, 7 burst ROM->RAM.
//   Codes 0..2 are ignored. Function 7 repeats the sequence BURST_LEN times,
//   and the address increments (with wrap) between transfers.
//
// Parameters:
//   AW        address width in bits
//   WAIT      extra STROBE clocks (STROBE lasts WAIT+1 clocks), 0..7
//   BURST_LEN number of transfers made by function 7, 1..2^AW
//
// Ports:
//   CK2HZ    in   1   clock, rising edge
//   CLR      in   1   asynchronous active-high reset
//   GO       in   1   start request, asynchronous to CK2HZ
//   FUNC     in   3   function code, latched at start
//   ADD      in   AW  start address, latched at start
//   ADDR     out  AW  bus address
//   n_ROMO   out  1   ROM output enable (active low)
//   n_RAMO   out  1   RAM output enable (active low)
//   n_RAMW   out  1   RAM write strobe (active low)
//   n_SWBEN  out  1   switch buffer enable (active low)
//   LEDLTCH  out  1   LED latch strobe (active high)
//   St       out  2   state code 00 IDLE, 01 SETUP, 10 STROBE, 11 HOLD
//   BUSY     out  1   high whenever St != IDLE
//   DONE     out  1   one-clock pulse in the first IDLE cycle after completion
// -----------------------------------------------------------------------------
module bus_sequencer #(
    parameter int AW        = 4,
    parameter int WAIT      = 1,
    parameter int BURST_LEN = 4
) (
    input  logic          CK2HZ,
    input  logic          CLR,
    input  logic          GO,
    input  logic [2:0]    FUNC,
    input  logic [AW-1:0] ADD,
    output logic [AW-1:0] ADDR,
    output logic          n_ROMO,
    output logic          n_RAMO,
    output logic          n_RAMW,
    output logic          n_SWBEN,
    output logic          LEDLTCH,
    output logic [1:0]    St,
    output logic          BUSY,
    output logic          DONE
);

    // The burst counter holds the number of transfers still to follow the
    // current one. One spare bit keeps it safe for BURST_LEN = 2^AW.
    localparam int            CW        = AW + 1;
    localparam logic [CW-1:0] BURST_M1  = CW'(BURST_LEN - 1);
    localparam logic [2:0]    WAIT_LAST = 3'(WAIT);

    // The encoding is the externally visible St code.
    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_SETUP  = 2'b01,
        S_STROBE = 2'b10,
        S_HOLD   = 2'b11
    } state_t;

    // -------------------------------------------------------------------------
    // GO synchroniser and rising-edge detector
    // -------------------------------------------------------------------------
    logic go_meta_q;
    logic go_sync_q;
    logic go_prev_q;
    logic go_edge;

    always_ff @(posedge CK2HZ or posedge CLR) begin
        if (CLR) begin
            go_meta_q <= 1'b0;
            go_sync_q <= 1'b0;
            go_prev_q <= 1'b0;
        end else begin
            go_meta_q <= GO;
            go_sync_q <= go_meta_q;
            go_prev_q <= go_sync_q;
        end
    end

    // The edge is seen for one clock only. If the sequencer is busy during
    // that clock, the edge is lost. This gives the "discard, not queue"
    // behaviour, and a GO that is held high cannot retrigger.
    assign go_edge = go_sync_q & ~go_prev_q;

    // -------------------------------------------------------------------------
    // Sequencer state
    // -------------------------------------------------------------------------
    state_t         state_q, state_d;
    logic [2:0]     func_q, func_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [2:0]     wcnt_q, wcnt_d;
    logic [CW-1:0]  rem_q, rem_d;

    // Registered copies of the bus controls
    logic           rom_oe_n_q, rom_oe_n_d;
    logic           ram_oe_n_q, ram_oe_n_d;
    logic           ram_we_n_q, ram_we_n_d;
    logic           sw_en_n_q,  sw_en_n_d;
    logic           led_ltch_q, led_ltch_d;
    logic           busy_q,     busy_d;
    logic           done_q,     done_d;

    logic           active_d;
    logic           strobe_d;

    always_comb begin
        state_d = state_q;
        func_d  = func_q;
        addr_d  = addr_q;
        wcnt_d  = wcnt_q;
        rem_d   = rem_q;

        case (state_q)
            S_IDLE: begin
                if (go_edge && (FUNC >= 3'd3)) begin
                    state_d = S_SETUP;
                    func_d  = FUNC;
                    addr_d  = ADD;
                    wcnt_d  = 3'd0;
                    rem_d   = (FUNC == 3'd7) ? BURST_M1 : '0;
                end
            end
            S_SETUP: begin
                state_d = S_STROBE;
                wcnt_d  = 3'd0;
            end
            S_STROBE: begin
                if (wcnt_q == WAIT_LAST) begin
                    state_d = S_HOLD;
                end else begin
                    wcnt_d = wcnt_q + 3'd1;
                end
            end
            S_HOLD: begin
                // Only a burst has further transfers. For the other functions,
                // rem_q is always zero.
                if ((func_q == 3'd7) && (rem_q != '0)) begin
                    state_d = S_SETUP;
                    addr_d  = addr_q + AW'(1);
                    rem_d   = rem_q - CW'(1);
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase

        // Outputs come from the next state, so they register in step with St.
        // func_d keeps its old value in IDLE. Every enable is gated by
        // active_d, so the stale value does no harm.
        active_d = (state_d != S_IDLE);
        strobe_d = (state_d == S_STROBE);

        rom_oe_n_d = ~(active_d && ((func_d == 3'd3) || (func_d == 3'd6) || (func_d == 3'd7)));
        ram_oe_n_d = ~(active_d && (func_d == 3'd4));
        sw_en_n_d  = ~(active_d && (func_d == 3'd5));
        ram_we_n_d = ~(strobe_d && ((func_d == 3'd5) || (func_d == 3'd6) || (func_d == 3'd7)));
        led_ltch_d = strobe_d && ((func_d == 3'd3) || (func_d == 3'd4));
        busy_d     = active_d;
        done_d     = (state_q == S_HOLD) && (state_d == S_IDLE);
    end

    always_ff @(posedge CK2HZ or posedge CLR) begin
        if (CLR) begin
            state_q    <= S_IDLE;
            func_q     <= 3'd0;
            addr_q     <= '0;
            wcnt_q     <= 3'd0;
            rem_q      <= '0;
            rom_oe_n_q <= 1'b1;
            ram_oe_n_q <= 1'b1;
            ram_we_n_q <= 1'b1;
            sw_en_n_q  <= 1'b1;
            led_ltch_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            func_q     <= func_d;
            addr_q     <= addr_d;
            wcnt_q     <= wcnt_d;
            rem_q      <= rem_d;
            rom_oe_n_q <= rom_oe_n_d;
            ram_oe_n_q <= ram_oe_n_d;
            ram_we_n_q <= ram_we_n_d;
            sw_en_n_q  <= sw_en_n_d;
            led_ltch_q <= led_ltch_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign St      = state_q;
    assign ADDR    = addr_q;
    assign n_ROMO  = rom_oe_n_q;
    assign n_RAMO  = ram_oe_n_q;
    assign n_RAMW  = ram_we_n_q;
    assign n_SWBEN = sw_en_n_q;
    assign LEDLTCH = led_ltch_q;
    assign BUSY    = busy_q;
    assign DONE    = done_q;

endmodule

// File: tb/tb_bus_sequencer.sv
// -----------------------------------------------------------------------------
// tb_bus_sequencer
//
// Two builds of bus_sequencer (WAIT=1 and WAIT=3, both AW=4, BURST_LEN=4)
// share one set of inputs. For each operation, the bench derives the expected
// per-clock output trace of each build from the function table and timing
// rules. It then compares both builds every clock, sampling #1 after the
// rising edge.
// -----------------------------------------------------------------------------
module tb_bus_sequencer;

    localparam int AW   = 4;
    localparam int BL   = 4;
    localparam int NCYC = 32;            // checked window per operation
    localparam int NTOT = NCYC + 4;      // plus quiet tail with GO low

    logic          CK2HZ = 1'b0;
    logic          CLR   = 1'b1;
    logic          GO    = 1'b0;
    logic [2:0]    FUNC  = 3'd0;
    logic [AW-1:0] ADD   = '0;

    logic [AW-1:0] addr0, addr1;
    logic n_romo0, n_ramo0, n_ramw0, n_swben0, led0, busy0, done0;
    logic n_romo1, n_ramo1, n_ramw1, n_swben1, led1, busy1, done1;
    logic [1:0] st0, st1;

    always #5 CK2HZ = ~CK2HZ;

    bus_sequencer #(.AW(AW), .WAIT(1), .BURST_LEN(BL)) u_dut_w1 (
        .CK2HZ(CK2HZ), .CLR(CLR), .GO(GO), .FUNC(FUNC), .ADD(ADD),
        .ADDR(addr0), .n_ROMO(n_romo0), .n_RAMO(n_ramo0), .n_RAMW(n_ramw0),
        .n_SWBEN(n_swben0), .LEDLTCH(led0), .St(st0), .BUSY(busy0), .DONE(done0)
    );

    bus_sequencer #(.AW(AW), .WAIT(3), .BURST_LEN(BL)) u_dut_w3 (
        .CK2HZ(CK2HZ), .CLR(CLR), .GO(GO), .FUNC(FUNC), .ADD(ADD),
        .ADDR(addr1), .n_ROMO(n_romo1), .n_RAMO(n_ramo1), .n_RAMW(n_ramw1),
        .n_SWBEN(n_swben1), .LEDLTCH(led1), .St(st1), .BUSY(busy1), .DONE(done1)
    );

    // Vector layout: {St, BUSY, DONE, n_ROMO, n_RAMO, n_RAMW, n_SWBEN, LEDLTCH, ADDR}
    logic [12:0] exp_tr [0:1][0:NTOT];
    logic [3:0]  last_addr [0:1];
    int          n_checks = 0;
    int          n_pass   = 0;

    function automatic logic [12:0] obs_vec(input int sel);
        if (sel == 0)
            return {st0, busy0, done0, n_romo0, n_ramo0, n_ramw0, n_swben0, led0, addr0};
        else
            return {st1, busy1, done1, n_romo1, n_ramo1, n_ramw1, n_swben1, led1, addr1};
    endfunction

    // Expected outputs for one clock of a transfer phase, taken from the
    // function table. st=0 means idle.
    function automatic logic [12:0] vec(input logic [1:0] st, input logic [2:0] f,
                                        input logic [3:0] ad, input logic done);
        logic act, stb;
        act = (st != 2'b00);
        stb = (st == 2'b10);
        return {st, act, done,
                ~(act && (f == 3'd3 || f == 3'd6 || f == 3'd7)),
                ~(act && f == 3'd4),
                ~(stb && (f == 3'd5 || f == 3'd6 || f == 3'd7)),
                ~(act && f == 3'd5),
                stb && (f == 3'd3 || f == 3'd4),
                ad};
    endfunction

    // Expected trace, indexed by the rising edge counted from the clock that
    // first samples GO high. The sequencer enters SETUP on edge 3.
    task automatic build(input int sel, input int wt, input logic [2:0] f,
                         input logic [3:0] a);
        int c;
        int nt;
        logic [3:0] ad;
        logic [3:0] la;
        la = last_addr[sel];
        for (int j = 0; j <= NTOT; j++) exp_tr[sel][j] = vec(2'b00, 3'd0, la, 1'b0);
        if (f >= 3'd3) begin
            nt = (f == 3'd7) ? BL : 1;
            c  = 3;
            for (int k = 0; k < nt; k++) begin
                ad = a + 4'(k);
                exp_tr[sel][c] = vec(2'b01, f, ad, 1'b0); c++;
                for (int w = 0; w <= wt; w++) begin
                    exp_tr[sel][c] = vec(2'b10, f, ad, 1'b0); c++;
                end
                exp_tr[sel][c] = vec(2'b11, f, ad, 1'b0); c++;
                la = ad;
            end
            for (int j = c; j <= NTOT; j++) exp_tr[sel][j] = vec(2'b00, 3'd0, la, j == c);
            last_addr[sel] = la;
        end
    endtask

    task automatic chk(input string tag, input logic [12:0] o, input logic [12:0] e);
        n_checks++;
        assert (o === e) n_pass++;
        else $error("FAIL %s got=%h exp=%h", tag, o, e);
    endtask

    task automatic chk_both(input string tag, input int c);
        chk($sformatf("%s_w1_c%0d", tag, c), obs_vec(0), exp_tr[0][c]);
        chk($sformatf("%s_w3_c%0d", tag, c), obs_vec(1), exp_tr[1][c]);
    endtask

    // One operation. The call is made just after a rising edge. In simple
    // mode, GO is sampled high on edges 1..hold. In double mode, GO is sampled
    // 1,0,1,1,...: a second edge is seen while the sequencer is busy, and the
    // sequencer must drop it. midchg scrambles FUNC/ADD once the start has
    // happened.
    task automatic run_op(input string tag, input logic [2:0] f, input logic [3:0] a,
                          input int hold, input bit dbl, input bit midchg);
        build(0, 1, f, a);
        build(1, 3, f, a);
        FUNC = f;
        ADD  = a;
        GO   = 1'b1;
        for (int c = 1; c <= NTOT; c++) begin
            @(posedge CK2HZ);
            #1;
            chk_both(tag, c);
            if (dbl) GO = (c + 1 != 2) && (c + 1 <= NCYC);
            else     GO = (c + 1 <= hold) && (c + 1 <= NCYC);
            if (midchg && c >= 3) begin
                FUNC = 3'($urandom_range(0, 7));
                ADD  = 4'($urandom_range(0, 15));
            end
        end
        $display("op %s func=%0d add=%0d hold=%0d dbl=%0d mid=%0d", tag, f, a, hold, dbl, midchg);
    endtask

    initial begin
        logic [2:0] rf;
        logic [3:0] ra;
        bit rdbl;
        last_addr[0] = 4'd0;
        last_addr[1] = 4'd0;

        // Hold reset across two edges, then check reset values.
        for (int j = 0; j <= NTOT; j++) begin
            exp_tr[0][j] = vec(2'b00, 3'd0, 4'd0, 1'b0);
            exp_tr[1][j] = vec(2'b00, 3'd0, 4'd0, 1'b0);
        end
        @(posedge CK2HZ); @(posedge CK2HZ); #1;
        chk_both("reset", 0);
        CLR = 1'b0;
        @(posedge CK2HZ); #1;
        chk_both("post_reset", 0);

        // Ignored function codes
        run_op("f0", 3'd0, 4'd5, 3, 1'b0, 1'b0);
        run_op("f1", 3'd1, 4'd6, 3, 1'b0, 1'b0);
        run_op("f2", 3'd2, 4'd7, 3, 1'b0, 1'b0);

        // Directed functions. GO stays high well past the end of f3 to show
        // that it does not retrigger.
        run_op("f3", 3'd3, 4'd9, 6, 1'b0, 1'b0);
        run_op("f3_long", 3'd3, 4'd9, NCYC, 1'b0, 1'b0);
        run_op("f5", 3'd5, 4'd3, 2, 1'b0, 1'b1);
        run_op("f6", 3'd6, 4'd12, 2, 1'b0, 1'b1);
        run_op("f7_wrap", 3'd7, 4'd14, 4, 1'b0, 1'b1);
        run_op("f4", 3'd4, 4'd1, 2, 1'b0, 1'b0);
        run_op("f3_dbl", 3'd3, 4'd2, 0, 1'b1, 1'b0);
        run_op("f7_dbl", 3'd7, 4'd15, 0, 1'b1, 1'b0);

        // Randomised operations
        for (int n = 0; n < 20; n++) begin
            rf   = 3'($urandom_range(0, 7));
            ra   = 4'($urandom_range(0, 15));
            rdbl = ($urandom_range(0, 3) == 0);
            run_op($sformatf("rnd%0d", n), rf, ra, int'($urandom_range(1, NCYC)),
                   rdbl, !rdbl && ($urandom_range(0, 1) == 1));
        end

        // Abort a burst during STROBE of its second transfer (WAIT=1 build).
        build(0, 1, 3'd7, 4'd2);
        build(1, 3, 3'd7, 4'd2);
        FUNC = 3'd7;
        ADD  = 4'd2;
        GO   = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(posedge CK2HZ);
            #1;
            chk_both("abort_pre", c);
            GO = (c + 1 <= 3);
        end
        #2;
        CLR = 1'b1;
        #1;
        last_addr[0] = 4'd0;
        last_addr[1] = 4'd0;
        for (int j = 0; j <= NTOT; j++) begin
            exp_tr[0][j] = vec(2'b00, 3'd0, 4'd0, 1'b0);
            exp_tr[1][j] = vec(2'b00, 3'd0, 4'd0, 1'b0);
        end
        chk_both("abort_async", 0);
        @(posedge CK2HZ); #1;
        chk_both("abort_held", 0);
        CLR = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(posedge CK2HZ); #1;
            chk_both("abort_quiet", c);
        end
        $display("op abort func=7 add=2");
        run_op("fresh", 3'd6, 4'd11, 2, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bus_sequencer.md
Name: bus_sequencer

Overview:
- Parametrised successor to the PlayBus starter.
- Accepts an asynchronous GO request and a 3-bit function code, then drives the PlayBus strobes (ROM/RAM output enables, RAM write, switch-buffer enable, LED latch) through a timed SETUP/STROBE/HOLD sequence.
- Adds configurable address width, configurable strobe wait states, edge-qualified GO, BUSY/DONE handshake, and a multi-address burst copy function.
- Sits between the front-panel controls and the PlayBus memory/LED devices.

Parameters:
- AW, 4, address bus width in bits.
- WAIT, 1, extra STROBE cycles; STROBE lasts WAIT+1 clocks; legal range 0..7.
- BURST_LEN, 4, number of addresses transferred by FUNC=7; legal range 1..2^AW.

Ports:
- CK2HZ  input  1  system clock, rising-edge active.
- CLR  input  1  reset, asynchronous, active-high.
- GO  input  1  start request, asynchronous to CK2HZ.
- FUNC  input  3  function code, sampled at start.
- ADD  input  AW  start address, sampled at start.
- ADDR  output  AW  bus address.
- n_ROMO  output  1  ROM output enable, active-low.
- n_RAMO  output  1  RAM output enable, active-low.
- n_RAMW  output  1  RAM write strobe, active-low.
- n_SWBEN  output  1  switch buffer enable, active-low.
- LEDLTCH  output  1  LED latch strobe, active-high.
- St  output  2  state code: 00 IDLE, 01 SETUP, 10 STROBE, 11 HOLD.
- BUSY  output  1  high whenever St != IDLE.
- DONE  output  1  one-clock pulse on completion.

Behaviour:
- Reset: CLR=1 forces immediately, regardless of clock: St=00, ADDR=0, n_ROMO=n_RAMO=n_RAMW=n_SWBEN=1, LEDLTCH=0, BUSY=0, DONE=0, synchroniser flops=0. This applies mid-operation too; the aborted operation is dropped, and no DONE is issued.
- GO handling:
  - Two-flop synchroniser, then rising-edge detect (sync2 & ~prev).
  - A start occurs only when state is IDLE, an edge is detected, and FUNC is 3..7.
  - Latency: SETUP is entered on the 3rd rising CK2HZ edge that samples GO high.
  - FUNC 0..2: GO ignored, no bus activity, no DONE.
  - A GO held high after completion does not retrigger; GO must return low first.
  - Edges occurring while BUSY are discarded, not queued.
- At start, FUNC and ADD are latched. Later input changes have no effect until the next start.
- Enables (asserted in SETUP, STROBE and HOLD):
  - F3 ROM->LED: n_ROMO.
  - F4 RAM->LED: n_RAMO.
  - F5 SW->RAM: n_SWBEN.
  - F6 ROM->RAM: n_ROMO.
  - F7 burst ROM->RAM: n_ROMO.
- Strobes (asserted in STROBE only):
  - F3, F4: LEDLTCH=1.
  - F5, F6, F7: n_RAMW=0.
  - No overlap: a strobe is never asserted in SETUP or HOLD.
- Transitions:
  - IDLE->SETUP on start.
  - SETUP->STROBE after 1 clock.
  - STROBE->HOLD after WAIT+1 clocks.
  - HOLD->IDLE after 1 clock. Exception: F7 with remaining count > 0 goes HOLD->SETUP, with ADDR incremented by 1.
- Address rules:
  - ADDR = latched ADD during the first transfer.
  - ADDR increments modulo 2^AW (wrap 2^AW-1 -> 0).
  - ADDR holds its last value in IDLE.
- Burst counting: F7 performs exactly BURST_LEN transfers. The internal counter is wide enough for BURST_LEN = 2^AW.
- DONE is high for exactly one clock, in the first IDLE cycle after the final HOLD.
- BUSY is registered and coincident with St != 00.
- All outputs are registered and glitch-free. No combinational path exists from GO/FUNC/ADD to any output.
- Single-transfer length is WAIT+3 clocks. F7 length is BURST_LEN*(WAIT+3) clocks.

Test Plan:
- Reset and ignored functions: CLR pulse, then FUNC=0,1,2 each with a GO pulse -> St stays 00; all n_* stay 1; LEDLTCH=0; DONE never asserts.
- F3 with defaults: FUNC=3, ADD=9, GO held 6 clocks -> St sequence 01,10,10,11,00; n_ROMO=0 for 4 clocks; LEDLTCH=1 for 2 clocks within them; ADDR=9; one DONE pulse; no second run while GO stays high.
- F5 then F6: SW->RAM gives n_SWBEN=0 for 4 clocks with n_RAMW=0 only during St=10. ROM->RAM likewise with n_ROMO. Changing FUNC/ADD mid-run has no effect on outputs.
- F7 wrap: AW=4, BURST_LEN=4, ADD=14 -> ADDR sequence 14,15,0,1; four n_RAMW pulses; BUSY high for 16 clocks; single DONE at the end.
- WAIT=3 build: F4 -> STROBE lasts 4 clocks; BUSY lasts 6 clocks; n_RAMO=0 throughout BUSY.
- Abort: assert CLR during STROBE of F7 -> all outputs return to reset values immediately; no DONE; the next GO edge starts a fresh operation at the new ADD.
